// File: rtl/myCPU_pkg.sv
// myCPU_pkg
// Shared constants and types for the myCPU instruction-side memory path.
//   ROM_PBASE      physical base of the boot-ROM window
//   KSEG0_TAG/KSEG1_TAG  top three vaddr bits of the unmapped kernel segments
//   RESET_VECTOR   virtual address of the first fetch after reset
//   resp_t         one response slot: valid flag, error flag, instruction word
package myCPU_pkg;

   localparam logic [31:0] ROM_PBASE    = 32'h1FC0_0000;
   localparam logic [2:0]  KSEG0_TAG    = 3'b100;
   localparam logic [2:0]  KSEG1_TAG    = 3'b101;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } resp_t;

   // kseg0 and kseg1 both translate by stripping the top three bits
   function automatic logic isKseg01(input logic [2:0] tag);
      return (tag == KSEG0_TAG) || (tag == KSEG1_TAG);
   endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// inst_sram_responder_if
// Fetch request/response bundle between the IF stage and the instruction memory.
//   inst_sram_en     request valid                  (IF -> mem)
//   inst_sram_addr   32-bit fetch virtual address   (IF -> mem)
//   inst_sram_flush  drop in-flight responses       (IF -> mem)
//   inst_sram_ready  request can be taken this cycle (mem -> IF)
//   inst_sram_rvalid response valid pulse           (mem -> IF)
//   inst_sram_rdata  instruction word               (mem -> IF)
//   inst_sram_err    address error with rvalid      (mem -> IF)
interface inst_sram_responder_if;

   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_flush;
   logic        inst_sram_ready;
   logic        inst_sram_rvalid;
   logic [31:0] inst_sram_rdata;
   logic        inst_sram_err;

   modport master (
      output inst_sram_en, inst_sram_addr, inst_sram_flush,
      input  inst_sram_ready, inst_sram_rvalid, inst_sram_rdata, inst_sram_err
   );

   modport slave (
      input  inst_sram_en, inst_sram_addr, inst_sram_flush,
      output inst_sram_ready, inst_sram_rvalid, inst_sram_rdata, inst_sram_err
   );

endinterface

// File: rtl/inst_resp_delay_line.sv
// inst_resp_delay_line
// LATENCY-deep shift register of response slots. Stage 0 captures the slot
// built in the accept cycle; the last stage drives the response outputs.
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset, clears every slot
//   flush_i  clears the valid bit of every slot already in the line
//   resp_i   slot entering stage 0 this cycle (never cleared by flush)
//   resp_o   slot leaving the last stage
module inst_resp_delay_line
   import myCPU_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  flush_i,
   input  resp_t resp_i,
   output resp_t resp_o
);

   resp_t stage_q [LATENCY];
   resp_t stage_d [LATENCY];

   // Shift every slot one stage forward. A flush kills the slots that were
   // already in the line, but the incoming slot is the redirect target and
   // must survive, so only stages 1.. see the clear. The slot leaving the
   // last stage this cycle is already on the outputs and is not affected.
   always_comb begin
      stage_d[0] = resp_i;
      for (int i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
         if (flush_i) begin
            stage_d[i].valid = 1'b0;
         end
      end
   end

   // Register the line; reset empties every stage so nothing in flight
   // can reappear after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/inst_sram_responder.sv
// inst_sram_responder
// Instruction-side SRAM responder: translates kseg0/kseg1 fetch addresses,
// range-checks them against a boot-ROM-sized word array based at physical
// 0x1FC0_0000, and returns the word in order LATENCY cycles later.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        fetch request/response bundle (slave side)
//   load_en    preload write strobe (blocks requests that cycle)
//   load_idx   preload word index
//   load_data  preload word
//   req_count  saturating count of accepted requests
module inst_sram_responder
   import myCPU_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   inst_sram_responder_if.slave  bus,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_idx,
   input  logic [31:0]           load_data,
   output logic [CNT_W-1:0]      req_count
);

   if ((LATENCY < 1) || (LATENCY > 4)) begin : gBadLatency
      $error("inst_sram_responder: LATENCY must lie in 1..4");
   end

   logic [31:0]           mem [2**DEPTH_LOG2];
   logic                  accept;
   logic [31:0]           paddr;
   logic [31:0]           offset;
   logic                  segOk;
   logic                  misaligned;
   logic                  inRange;
   logic                  addrErr;
   logic [DEPTH_LOG2-1:0] rdIdx;
   logic [31:0]           memWord;
   resp_t                 respIn;
   resp_t                 respOut;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;

   // Preload owns the array for the cycle, so requests are held off.
   assign bus.inst_sram_ready = !load_en;
   assign accept              = bus.inst_sram_en && !load_en;

   // Translate and check the fetch address. The window is word aligned, so
   // the low offset bits equal the low vaddr bits; the index is in range
   // exactly when every offset bit above the word index is zero.
   always_comb begin
      segOk      = isKseg01(bus.inst_sram_addr[31:29]);
      paddr      = {3'b000, bus.inst_sram_addr[28:0]};
      offset     = paddr - ROM_PBASE;
      misaligned = (offset[1:0] != 2'b00);
      inRange    = (paddr >= ROM_PBASE) && (offset[31:DEPTH_LOG2+2] == '0);
      addrErr    = !segOk || misaligned || !inRange;
      rdIdx      = offset[DEPTH_LOG2+1:2];
   end

   // The word is read in the accept cycle so a later preload to the same
   // index cannot change a response that is already in flight.
   assign memWord = mem[rdIdx];

   always_comb begin
      respIn.valid = accept;
      respIn.err   = addrErr;
      respIn.data  = addrErr ? 32'h0 : memWord;
   end

   // Memory contents survive reset; only the preload port writes them.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_idx] <= load_data;
      end
   end

   inst_resp_delay_line #(
      .LATENCY (LATENCY)
   ) uDelayLine (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.inst_sram_flush),
      .resp_i  (respIn),
      .resp_o  (respOut)
   );

   // Flushed slots keep stale data, so outputs are gated by valid.
   assign bus.inst_sram_rvalid = respOut.valid;
   assign bus.inst_sram_err    = respOut.valid && respOut.err;
   assign bus.inst_sram_rdata  = (respOut.valid && !respOut.err) ? respOut.data : 32'h0;

   // Count every accepted request, errored or not, and stick at all-ones.
   always_comb begin
      count_d = count_q;
      if (accept && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign req_count = count_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder
// Drives one shared stimulus stream into three responders (LATENCY 1/2/3,
// counter widths 16/4/4) and compares each against a reference model built
// from an accept log, a flush log and a reset log indexed by cycle.
module tb_inst_sram_responder;
   import myCPU_pkg::*;

   localparam int DEPTH  = 4096;
   localparam int MAXCYC = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] addr;
   logic        flush;
   logic        loadEn;
   logic [11:0] loadIdx;
   logic [31:0] loadData;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;
   logic [3:0]  cnt2;

   always #5 clk = ~clk;

   inst_sram_responder_if if0 ();
   inst_sram_responder_if if1 ();
   inst_sram_responder_if if2 ();

   assign if0.inst_sram_en = en;
   assign if0.inst_sram_addr = addr;
   assign if0.inst_sram_flush = flush;
   assign if1.inst_sram_en = en;
   assign if1.inst_sram_addr = addr;
   assign if1.inst_sram_flush = flush;
   assign if2.inst_sram_en = en;
   assign if2.inst_sram_addr = addr;
   assign if2.inst_sram_flush = flush;

   inst_sram_responder #(.DEPTH_LOG2(12), .LATENCY(1), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .bus(if0), .load_en(loadEn), .load_idx(loadIdx),
      .load_data(loadData), .req_count(cnt0));
   inst_sram_responder #(.DEPTH_LOG2(12), .LATENCY(2), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .bus(if1), .load_en(loadEn), .load_idx(loadIdx),
      .load_data(loadData), .req_count(cnt1));
   inst_sram_responder #(.DEPTH_LOG2(12), .LATENCY(3), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .bus(if2), .load_en(loadEn), .load_idx(loadIdx),
      .load_data(loadData), .req_count(cnt2));

   logic        obsR [3];
   logic        obsV [3];
   logic [31:0] obsD [3];
   logic        obsE [3];
   logic [15:0] obsC [3];

   assign obsR[0] = if0.inst_sram_ready;
   assign obsR[1] = if1.inst_sram_ready;
   assign obsR[2] = if2.inst_sram_ready;
   assign obsV[0] = if0.inst_sram_rvalid;
   assign obsV[1] = if1.inst_sram_rvalid;
   assign obsV[2] = if2.inst_sram_rvalid;
   assign obsD[0] = if0.inst_sram_rdata;
   assign obsD[1] = if1.inst_sram_rdata;
   assign obsD[2] = if2.inst_sram_rdata;
   assign obsE[0] = if0.inst_sram_err;
   assign obsE[1] = if1.inst_sram_err;
   assign obsE[2] = if2.inst_sram_err;
   assign obsC[0] = cnt0;
   assign obsC[1] = {12'h0, cnt1};
   assign obsC[2] = {12'h0, cnt2};

   // Reference model state
   logic [31:0] memModel [DEPTH];
   bit          accV [MAXCYC];
   logic        accE [MAXCYC];
   logic [31:0] accD [MAXCYC];
   bit          flushLog [MAXCYC];
   bit          rstLog [MAXCYC];
   int          lat [3];
   int          satMax [3];
   int          cyc;
   int          acceptsSinceReset;
   logic        expV [3];
   logic [31:0] expD [3];
   logic        expE [3];
   logic [15:0] expC [3];
   int          nChecks;
   int          nFail;

   // Address rules: kseg0/kseg1 only, word aligned, inside the ROM window
   function automatic void refAccess(input logic [31:0] va, output logic e, output logic [31:0] d);
      int unsigned seg;
      int unsigned pa;
      int unsigned idx;
      seg = va / 32'h2000_0000;
      pa  = va % 32'h2000_0000;
      idx = 0;
      e   = 1'b0;
      d   = 32'h0;
      if (seg != 4 && seg != 5) e = 1'b1;
      if ((va % 4) != 0) e = 1'b1;
      if (pa < 32'h1FC0_0000) e = 1'b1;
      else begin
         idx = (pa - 32'h1FC0_0000) / 4;
         if (idx >= DEPTH) e = 1'b1;
      end
      if (!e) d = memModel[idx[11:0]];
   endfunction

   // Advance one clock: log what the edge does, then derive what each
   // responder must show in the new cycle, and return at the falling edge.
   task automatic tick();
      logic        e;
      logic [31:0] d;
      @(posedge clk);
      if (loadEn) memModel[loadIdx] = loadData;
      else if (rst && en) begin
         refAccess(addr, e, d);
         accV[cyc] = 1'b1;
         accE[cyc] = e;
         accD[cyc] = d;
         acceptsSinceReset++;
      end
      flushLog[cyc] = rst && flush;
      cyc++;
      if (cyc >= MAXCYC) begin
         $display("[TB] FAIL cycle_budget: cyc=%0d, limit=%0d", cyc, MAXCYC);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      rstLog[cyc] = !rst;
      for (int k = 0; k < 3; k++) begin
         int   a;
         logic v;
         a = cyc - lat[k];
         v = (a >= 0) && rst;
         if (v) v = accV[a];
         if (v) begin
            for (int c = a + 1; c < cyc; c++) begin
               if (flushLog[c] || rstLog[c]) v = 1'b0;
            end
         end
         expV[k] = v;
         expE[k] = v ? accE[a] : 1'b0;
         expD[k] = v ? accD[a] : 32'h0;
         expC[k] = !rst ? 16'h0 :
                   16'((acceptsSinceReset > satMax[k]) ? satMax[k] : acceptsSinceReset);
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic e, input logic [31:0] a, input logic f);
      en     = e;
      addr   = a;
      flush  = f;
      loadEn = 1'b0;
   endtask

   task automatic assertReset();
      rst = 1'b0;
      rstLog[cyc] = 1'b1;
      acceptsSinceReset = 0;
   endtask

   task automatic test_reset();
      assertReset();
      applyStimulus(1'b1, RESET_VECTOR, 1'b0);
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if (obsV[k] !== 1'b0 || obsD[k] !== 32'h0 || obsE[k] !== 1'b0 || obsC[k] !== 16'h0 || obsR[k] !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reset_state dut%0d: got v=%b d=%h e=%b cnt=%0d rdy=%b, want 0 0 0 0 rdy=1",
                     k, obsV[k], obsD[k], obsE[k], obsC[k], obsR[k]);
         end
      end
      loadEn = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if (obsR[k] !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset_ready dut%0d: got %b, want 0", k, obsR[k]);
         end
      end
      loadEn = 1'b0;
      en = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_preload();
      for (int i = 0; i < DEPTH; i++) begin
         en       = 1'($urandom_range(0, 1));
         addr     = RESET_VECTOR + 32'(4 * $urandom_range(0, 7));
         flush    = 1'b0;
         loadEn   = 1'b1;
         loadIdx  = 12'(i);
         loadData = (i == 0) ? 32'h2408_0001 : (i == 1) ? 32'h2409_0002 : $urandom;
         #1;
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsR[k] !== 1'b0 || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL preload_hold dut%0d idx%0d: got rdy=%b cnt=%0d, want rdy=0 cnt=%0d",
                        k, i, obsR[k], obsC[k], expC[k]);
            end
         end
         tick();
      end
      loadEn = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] seq [6] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i < 2, seq[i], 1'b0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL basic dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
      nChecks++;
      if (obsC[0] !== 16'd2) begin
         nFail++;
         $display("[TB] FAIL basic_count: got %0d, want 2", obsC[0]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] seq [13] = '{32'hBFC0_0002, 32'h0000_1000, 32'hBFC0_4000, 32'hBFC0_3FFC,
                                32'h9FC0_0000, 32'h7FC0_0000, 32'hDFC0_0000, 32'h9FBF_FFFC,
                                32'hA000_0000, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 13; i++) begin
         applyStimulus(i < 9, seq[i], 1'b0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL addr_err dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i < 3, 32'hBFC0_0010 + 32'(4 * i), i == 2);
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL flush dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
   endtask

   task automatic test_load_hold();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(i < 3, 32'hBFC0_0008, 1'b0);
         loadEn   = (i < 2);
         loadIdx  = 12'd2;
         loadData = 32'hC0DE_0000 + 32'(i);
         #1;
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsR[k] !== !loadEn) begin
               nFail++;
               $display("[TB] FAIL load_ready dut%0d step%0d: got %b, want %b", k, i, obsR[k], !loadEn);
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL load_hold dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
   endtask

   task automatic test_reset_inflight();
      applyStimulus(1'b1, 32'hBFC0_000C, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      assertReset();
      #1;
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if (obsV[k] !== 1'b0 || obsD[k] !== 32'h0 || obsE[k] !== 1'b0 || obsC[k] !== 16'h0) begin
            nFail++;
            $display("[TB] FAIL reset_async dut%0d: got v=%b d=%h e=%b cnt=%0d, want all 0",
                     k, obsV[k], obsD[k], obsE[k], obsC[k]);
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) rst = 1'b1;
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL reset_inflight dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] va;
         logic [31:0] pa;
         int          pick;
         pick = $urandom_range(0, 99);
         pa   = 32'h1FC0_0000 + 32'(4 * $urandom_range(0, DEPTH + 1));
         va   = {3'($urandom_range(4, 5)), pa[28:0]};
         if (pick < 10) va = $urandom;
         else if (pick < 18) va = va + 32'($urandom_range(1, 3));
         applyStimulus($urandom_range(0, 3) != 0, va, $urandom_range(0, 9) == 0);
         loadEn   = ($urandom_range(0, 99) < 8);
         loadIdx  = 12'($urandom);
         loadData = $urandom;
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL random dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      applyStimulus(1'b0, 32'h0, 1'b0);
      assertReset();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 24; i++) begin
         applyStimulus(i < 20, RESET_VECTOR + 32'(4 * i), 1'b0);
         tick();
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (obsV[k] !== expV[k] || obsD[k] !== expD[k] || obsE[k] !== expE[k] || obsC[k] !== expC[k]) begin
               nFail++;
               $display("[TB] FAIL saturate dut%0d cyc%0d: got v=%b d=%h e=%b cnt=%0d, want v=%b d=%h e=%b cnt=%0d",
                        k, cyc, obsV[k], obsD[k], obsE[k], obsC[k], expV[k], expD[k], expE[k], expC[k]);
            end
         end
      end
      nChecks++;
      if (obsC[0] !== 16'd20 || obsC[1] !== 16'd15 || obsC[2] !== 16'd15) begin
         nFail++;
         $display("[TB] FAIL saturate_final: got %0d/%0d/%0d, want 20/15/15", obsC[0], obsC[1], obsC[2]);
      end
   endtask

   initial begin
      lat       = '{1, 2, 3};
      satMax    = '{65535, 15, 15};
      cyc       = 0;
      nChecks   = 0;
      nFail     = 0;
      acceptsSinceReset = 0;
      en        = 1'b0;
      addr      = 32'h0;
      flush     = 1'b0;
      loadEn    = 1'b0;
      loadIdx   = 12'h0;
      loadData  = 32'h0;
      rst       = 1'b0;
      for (int k = 0; k < 3; k++) begin
         expV[k] = 1'b0;
         expD[k] = 32'h0;
         expE[k] = 1'b0;
         expC[k] = 16'h0;
      end
      #2;
      test_reset();
      test_preload();
      test_basic();
      test_errors();
      test_flush();
      test_load_hold();
      test_reset_inflight();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
